// File: rtl/afifo_pkg.sv
// Shared definitions for the afifo read-side burst controller.
// Holds default sizes, the FSM state encoding and the counter width.
package afifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;
    localparam int CNT_W     = ASIZE_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/afifo_burst_reader_if.sv
// Downstream valid/ready stream of the burst reader.
// master: m_data, m_valid out, m_ready in; slave is the mirror.
interface afifo_burst_reader_if
    import afifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
);

    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/afifo_out_reg.sv
// Single-entry valid/ready output register.
// Ports: load/d capture a word, m_ready drains it, slot_free allows a load.
module afifo_out_reg
    import afifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             load,
    input  logic [DSIZE-1:0] d,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    output logic             slot_free
);

    // A load may replace the word that is leaving in the same cycle.
    assign slot_free = !m_valid || m_ready;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
        end else if (load) begin
            m_data  <= d;
            m_valid <= 1'b1;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/afifo_burst_reader.sv
// Read-domain burst controller: pops burst_len words from afifo, streams them.
// Ports: rclk/rrst_n, start/burst_len, rdata/rempty/rinc, m (stream), busy/done/remaining.
module afifo_burst_reader
    import afifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic               rclk,
    input  logic               rrst_n,
    input  logic               start,
    input  logic [ASIZE:0]     burst_len,
    input  logic [DSIZE-1:0]   rdata,
    input  logic               rempty,
    output logic               rinc,
    output logic               busy,
    output logic               done,
    output logic [ASIZE:0]     remaining,
    afifo_burst_reader_if.master m
);

    localparam int CW = ASIZE + 1;

    state_t           state;
    logic             slot_free;
    logic [DSIZE-1:0] q_data;
    logic             q_valid;

    // Combinational so a reset or an empty flag kills the pop instantly.
    assign rinc = (state == ST_RUN)
               && (remaining != '0)
               && !rempty
               && slot_free;

    afifo_out_reg #(
        .DSIZE (DSIZE)
    ) u_out (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .load      (rinc),
        .d         (rdata),
        .m_ready   (m.m_ready),
        .m_data    (q_data),
        .m_valid   (q_valid),
        .slot_free (slot_free)
    );

    assign m.m_data  = q_data;
    assign m.m_valid = q_valid;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            remaining <= burst_len;
                            state     <= ST_RUN;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rinc) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == CW'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Only the last word can be in the register here.
                    if (q_valid && m.m_ready) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_burst_reader.sv
// Directed bench for afifo_burst_reader with a behavioural FWFT FIFO.
// Scoreboard queue holds expected stream words, checked on each handshake.
module tb_afifo_burst_reader;
    import afifo_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   burst_len = '0;
    logic [DW-1:0] rdata;
    logic          rempty;
    logic          rinc;
    logic          busy;
    logic          done;
    logic [AW:0]   remaining;

    afifo_burst_reader_if #(.DSIZE(DW)) m_if ();

    afifo_burst_reader #(
        .DSIZE (DW),
        .ASIZE (AW)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .start     (start),
        .burst_len (burst_len),
        .rdata     (rdata),
        .rempty    (rempty),
        .rinc      (rinc),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .m         (m_if.master)
    );

    always #5 rclk = ~rclk;

    logic [DW-1:0] mem [0:31];
    int wp = 0;
    int rp = 0;
    int pop_cnt = 0;
    int cyc = 0;
    int last_hs = 0;
    int checks = 0;
    int failures = 0;
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q [$];

    assign rempty = (wp == rp);
    assign rdata  = mem[rp[4:0]];

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rinc) begin
            rp      <= rp + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge rclk) begin
        if (rrst_n) begin
            chk("rinc_while_empty", {31'd0, rinc && rempty}, 0);
            if (m_if.m_valid && m_if.m_ready) begin
                chk("sb_has_word", {31'd0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    chk("m_data", {24'd0, m_if.m_data},
                        {24'd0, exp_q.pop_front()});
                end
                last_hs = cyc;
            end
        end
    end

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wp[4:0]] = v;
        wp++;
        model_q.push_back(v);
    endtask

    task automatic push_raw(input logic [DW-1:0] v);
        mem[wp[4:0]] = v;
        wp++;
    endtask

    task automatic expect_n(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_q.pop_front());
        end
    endtask

    task automatic go(input int len);
        step();
        start     = 1'b1;
        burst_len = len[AW:0];
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        @(negedge rclk);
        while (!done && n < limit) begin
            @(negedge rclk);
            n++;
        end
        chk("done_seen", {31'd0, done}, 1);
        if (done) begin
            chk("busy_at_done", {31'd0, busy}, 0);
            chk("done_after_hs", cyc - last_hs, 1);
            chk("sb_drained", exp_q.size(), 0);
            @(negedge rclk);
            chk("done_pulse", {31'd0, done}, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] held;
        int base;
        int n;

        m_if.m_ready = 1'b1;
        #3;
        chk("rst_rinc", {31'd0, rinc}, 0);
        chk("rst_m_valid", {31'd0, m_if.m_valid}, 0);
        chk("rst_m_data", {24'd0, m_if.m_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_remaining", {27'd0, remaining}, 0);
        #9;
        rrst_n = 1'b1;

        // Full FIFO, burst of 16 at full rate.
        for (int i = 0; i < 16; i++) push(DW'(i));
        expect_n(16);
        go(16);
        for (int i = 0; i < 16; i++) begin
            @(negedge rclk);
            chk("full_rinc", {31'd0, rinc}, 1);
            if (i == 0) chk("lat_m_valid_lo", {31'd0, m_if.m_valid}, 0);
            if (i == 1) chk("lat_m_valid_hi", {31'd0, m_if.m_valid}, 1);
            if (i == 0) chk("lat_busy", {31'd0, busy}, 1);
        end
        @(negedge rclk);
        chk("full_rinc_end", {31'd0, rinc}, 0);
        wait_done(40);
        chk("full_rempty", {31'd0, rempty}, 1);
        chk("full_remaining", {27'd0, remaining}, 0);

        // Split bursts 5 + 11.
        for (int i = 0; i < 16; i++) push(DW'(i));
        expect_n(5);
        go(5);
        wait_done(40);
        expect_n(11);
        go(11);
        wait_done(40);
        chk("split_rempty", {31'd0, rempty}, 1);

        // Downstream stall for three cycles.
        for (int i = 0; i < 16; i++) push(DW'(8'h30 + i));
        expect_n(16);
        go(16);
        repeat (4) step();
        m_if.m_ready = 1'b0;
        @(negedge rclk);
        held = m_if.m_data;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge rclk);
            chk("stall_rinc", {31'd0, rinc}, 0);
            chk("stall_valid", {31'd0, m_if.m_valid}, 1);
            chk("stall_data", {24'd0, m_if.m_data}, {24'd0, held});
        end
        step();
        m_if.m_ready = 1'b1;
        wait_done(60);

        // Start on an empty FIFO, slow writer.
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        go(3);
        repeat (4) begin
            @(negedge rclk);
            chk("empty_busy", {31'd0, busy}, 1);
            chk("empty_rinc", {31'd0, rinc}, 0);
        end
        step();
        push_raw(8'hA0);
        repeat (3) begin
            @(negedge rclk);
            chk("slow_busy", {31'd0, busy}, 1);
        end
        step();
        push_raw(8'hA1);
        repeat (3) begin
            @(negedge rclk);
            chk("slow_busy", {31'd0, busy}, 1);
        end
        step();
        push_raw(8'hA2);
        wait_done(40);

        // Zero-length burst.
        push(8'h55);
        step();
        start     = 1'b1;
        burst_len = '0;
        step();
        start     = 1'b0;
        @(negedge rclk);
        chk("zero_done", {31'd0, done}, 1);
        chk("zero_busy", {31'd0, busy}, 0);
        chk("zero_rinc", {31'd0, rinc}, 0);
        chk("zero_remaining", {27'd0, remaining}, 0);
        @(negedge rclk);
        chk("zero_done_pulse", {31'd0, done}, 0);
        chk("zero_rempty", {31'd0, rempty}, 0);

        // Start while busy is ignored.
        push(8'h56);
        push(8'h57);
        m_if.m_ready = 1'b0;
        expect_n(3);
        go(3);
        repeat (3) step();
        @(negedge rclk);
        chk("ign_remaining_pre", {27'd0, remaining}, 2);
        step();
        start     = 1'b1;
        burst_len = 5'd5;
        step();
        start     = 1'b0;
        @(negedge rclk);
        chk("ign_remaining", {27'd0, remaining}, 2);
        chk("ign_busy", {31'd0, busy}, 1);
        step();
        m_if.m_ready = 1'b1;
        wait_done(40);

        // Reset after four pops of a ten-word burst.
        for (int i = 0; i < 10; i++) push(DW'(i));
        expect_n(10);
        base = pop_cnt;
        go(10);
        n = 0;
        @(negedge rclk);
        while (pop_cnt != base + 4 && n < 40) begin
            @(negedge rclk);
            n++;
        end
        chk("rst_pops", pop_cnt - base, 4);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("mid_rinc", {31'd0, rinc}, 0);
        chk("mid_m_valid", {31'd0, m_if.m_valid}, 0);
        chk("mid_m_data", {24'd0, m_if.m_data}, 0);
        chk("mid_busy", {31'd0, busy}, 0);
        chk("mid_done", {31'd0, done}, 0);
        chk("mid_remaining", {27'd0, remaining}, 0);
        exp_q.delete();
        model_q.delete();
        for (int i = 4; i < 10; i++) model_q.push_back(DW'(i));
        @(posedge rclk);
        #3;
        chk("mid_fifo_count", wp - rp, 6);
        rrst_n = 1'b1;
        expect_n(6);
        go(6);
        wait_done(40);
        chk("post_rempty", {31'd0, rempty}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/afifo_burst_reader.md
# afifo_burst_reader

Read-side burst controller for the `afifo` async FIFO, running entirely in the read clock domain. On a `start` command it pops exactly `burst_len` words from the FIFO using `rinc`/`rempty`. It presents them to a downstream consumer on a registered valid/ready stream, then pulses `done`. It replaces free-running `rinc` toggling in benches and subsystems.

## Interface
Parameters:
- `DSIZE`, 8: data width; must match the `afifo` instance.
- `ASIZE`, 4: FIFO address width; FIFO depth is 2^ASIZE.

Ports:
- `rclk` in 1: read-domain clock. All logic is on its rising edge.
- `rrst_n` in 1: asynchronous active-low reset.
- `start` in 1: burst request. Sampled only in IDLE.
- `burst_len` in ASIZE+1: word count, sampled with `start`. Range 0..2^ASIZE.
- `rdata` in DSIZE: FIFO head word. First-word-fall-through: valid whenever `rempty`=0.
- `rempty` in 1: FIFO empty flag.
- `rinc` out 1: pop strobe to FIFO.
- `m_data` out DSIZE: registered output word.
- `m_valid` out 1: `m_data` valid.
- `m_ready` in 1: downstream accept.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at burst completion.
- `remaining` out ASIZE+1: words not yet popped in the current burst.

## Operation
- States: IDLE, RUN, DRAIN. Two-bit encoding with IDLE=0.
- IDLE:
  - `start`=1 with `burst_len`>0: load `remaining`=`burst_len` and go to RUN.
  - `start`=1 with `burst_len`=0: pulse `done` next cycle and stay IDLE.
- Pop condition (RUN only): `rinc` = `remaining`≠0 AND `rempty`=0 AND (`m_valid`=0 OR `m_ready`=1).
  - `rinc` is combinational from current state and inputs.
  - `rinc` is never asserted while `rempty`=1.
- On a pop:
  - `m_data`<=`rdata`, `m_valid`<=1, `remaining`<=`remaining`-1.
- On a handshake (`m_valid`&`m_ready`) with no simultaneous pop: `m_valid`<=0.
- A handshake and a pop in the same cycle: `m_valid` stays 1 and `m_data` takes the new word. This gives full throughput.
- RUN->DRAIN when the pop that takes `remaining` to 0 occurs.
- DRAIN:
  - No pops.
  - On the handshake of the last word: go to IDLE and assert `done` in the following cycle.
- `start` while `busy`=1 is ignored. No queuing.
- `m_data` holds its value when `m_valid`=0. It is not cleared.
- `rempty` rising mid-burst only stalls. `busy` stays high and no timeout applies.
- `m_valid`/`m_data` stay stable while `m_ready`=0.

## Timing
- Reset values:
  - `rinc`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0, `remaining`=0, state IDLE.
  - Reset is immediate on `rrst_n` falling, independent of `rclk`.
- Reset mid-burst:
  - The burst is abandoned and `rinc` drops the same instant.
  - FIFO contents are untouched. Words already popped but unaccepted are lost.
- Latency:
  - Start-to-first-pop is 1 cycle: `start` in cycle N, first `rinc` in cycle N+1 if the FIFO is non-empty.
  - `m_valid` rises in cycle N+2.
  - Head word in the pop cycle appears on `m_data` the next cycle.
- Throughput: 1 word/cycle with FIFO non-empty and `m_ready`=1.
- Completion: `done` is high exactly 1 cycle after the final handshake, with `busy` already low in that cycle. A new `start` is accepted in the `done` cycle.
- `burst_len`=2^ASIZE (all-ones+1, MSB set) is legal and pops a full FIFO.

## Structure
- Shared package `afifo_pkg` holds:
  - default `DSIZE`/`ASIZE`;
  - state localparams `ST_IDLE`, `ST_RUN`, `ST_DRAIN`;
  - helper width constant `CNT_W`=ASIZE+1.
- One natural sub-module: `afifo_out_reg`, the single-entry valid/ready output register.
  - It takes `load`, `d`, `m_ready` and produces `m_data`, `m_valid`, `slot_free`.
  - The FSM and `remaining` counter stay in the top.

## Test plan
- Fill `afifo` with 0..15, `burst_len`=16, `m_ready`=1.
  - Expect `rinc` high for 16 consecutive cycles.
  - Expect `m_data` 0..15 on 16 consecutive cycles and `done` one cycle after word 15.
  - Expect `rempty`=1 and `remaining`=0 at the end.
- FIFO holds 0..15, `burst_len`=5: expect words 0..4 out and `done`. A second `burst_len`=11 yields 5..15.
- `m_ready` held low for 3 cycles mid-burst.
  - Expect `m_data` stable and `rinc`=0 during the stall.
  - Expect no word lost or duplicated and the full sequence preserved.
- Start with the FIFO empty, then write 3 words 8'hA0..8'hA2 slowly on `wclk`.
  - Expect `busy`=1 throughout and pops only when `rempty`=0.
  - Expect `done` after 8'hA2 is accepted, with `burst_len`=3.
- `burst_len`=0: `done` one cycle after `start`, no `rinc`, `busy` never high. `start` while busy: ignored, `remaining` unchanged.
- Assert `rrst_n`=0 after 4 of 10 words have been popped.
  - Expect all outputs 0 immediately.
  - After reset release, a new `burst_len`=6 returns words 4..9.
